// File: rtl/i2c_slave_if.sv
// Bus-side signals of the I2C responder: the SCL/SDA wires plus the
// byte-level handshake toward the local logic.
interface i2c_slave_if;
   logic       scl;
   logic       sda_in;
   logic       sda_oe;
   logic [7:0] tx_data;
   logic       tx_req;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
   logic       bus_err;

   modport slave (
      input  scl, sda_in, tx_data,
      output sda_oe, tx_req, rx_data, rx_valid, busy, bus_err
   );

   modport master (
      output scl, sda_in, tx_data,
      input  sda_oe, tx_req, rx_data, rx_valid, busy, bus_err
   );
endinterface

// File: rtl/i2c_slave.sv
// I2C responder: answers to one 7-bit address, accepts write bytes and
// returns read bytes supplied by local logic. SCL/SDA are oversampled by
// clk through synchronizers; the responder never stretches SCL.
module i2c_slave #(
   parameter logic [6:0] SLAVE_ADDR  = 7'b0111001,
   parameter int         SYNC_STAGES = 2
) (
   input logic        clk,
   input logic        rst_n,
   i2c_slave_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE
   } state_t;

   localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   logic [STAGES-1:0] sclSync;
   logic [STAGES-1:0] sdaSync;
   logic              sclDly;
   logic              sdaDly;
   logic              sclNow;
   logic              sdaNow;
   logic              sclRise;
   logic              sclFall;
   logic              startDet;
   logic              stopDet;
   logic              framingErr;

   state_t     state;
   logic [3:0] bitCnt;
   logic [7:0] shiftReg;
   logic [7:0] rxData;
   logic       sdaOe;
   logic       txReq;
   logic       rxValid;
   logic       busyReg;
   logic       busErr;

   // Synchronizers reset to 1 so a released reset looks like an idle bus
   // and can never be mistaken for a START.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclSync <= '1;
         sdaSync <= '1;
         sclDly  <= 1'b1;
         sdaDly  <= 1'b1;
      end else begin
         sclSync <= {sclSync[STAGES-2:0], bus.scl};
         sdaSync <= {sdaSync[STAGES-2:0], bus.sda_in};
         sclDly  <= sclNow;
         sdaDly  <= sdaNow;
      end
   end

   assign sclNow     = sclSync[STAGES-1];
   assign sdaNow     = sdaSync[STAGES-1];
   assign sclRise    = sclNow & ~sclDly;
   assign sclFall    = ~sclNow & sclDly;
   assign startDet   = sclNow & sclDly & sdaDly & ~sdaNow;
   assign stopDet    = sclNow & sclDly & ~sdaDly & sdaNow;
   assign framingErr = (state != IDLE) && (state != IGNORE) && (bitCnt != 4'd0);

   // Protocol FSM. STOP beats START beats SCL edges. In ADDR the counter
   // follows rising edges, because the SCL fall that closes a START is not
   // a data bit; in WR and RD it follows falling edges, so the SCL rise that
   // opens a repeated START or STOP after an ACK slot leaves it at 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         bitCnt   <= 4'd0;
         shiftReg <= 8'h00;
         rxData   <= 8'h00;
         sdaOe    <= 1'b0;
         txReq    <= 1'b0;
         rxValid  <= 1'b0;
         busyReg  <= 1'b0;
         busErr   <= 1'b0;
      end else begin
         txReq   <= 1'b0;
         rxValid <= 1'b0;
         busErr  <= 1'b0;
         if (stopDet) begin
            busErr  <= framingErr;
            state   <= IDLE;
            sdaOe   <= 1'b0;
            busyReg <= 1'b0;
            bitCnt  <= 4'd0;
         end else if (startDet) begin
            busErr <= framingErr;
            state  <= ADDR;
            sdaOe  <= 1'b0;
            bitCnt <= 4'd0;
         end else begin
            case (state)
               IDLE, IGNORE: begin
                  sdaOe <= 1'b0;
               end
               ADDR: begin
                  if (sclRise) begin
                     shiftReg <= {shiftReg[6:0], sdaNow};
                     if (bitCnt == 4'd7) begin
                        bitCnt <= 4'd8;
                        if (shiftReg[6:0] == SLAVE_ADDR) begin
                           state   <= ADDR_ACK;
                           busyReg <= 1'b1;
                        end else begin
                           state   <= IGNORE;
                           busyReg <= 1'b0;
                        end
                     end else begin
                        bitCnt <= bitCnt + 4'd1;
                     end
                  end
               end
               ADDR_ACK: begin
                  if (sclFall) begin
                     if (bitCnt == 4'd8) begin
                        sdaOe  <= 1'b1;
                        bitCnt <= 4'd0;
                     end else if (shiftReg[0]) begin
                        state    <= RD;
                        shiftReg <= bus.tx_data;
                        txReq    <= 1'b1;
                        sdaOe    <= ~bus.tx_data[7];
                     end else begin
                        state <= WR;
                        sdaOe <= 1'b0;
                     end
                  end
               end
               WR: begin
                  if (sclRise) begin
                     shiftReg <= {shiftReg[6:0], sdaNow};
                     if (bitCnt == 4'd7) begin
                        rxData  <= {shiftReg[6:0], sdaNow};
                        rxValid <= 1'b1;
                        state   <= WR_ACK;
                        bitCnt  <= 4'd8;
                     end
                  end else if (sclFall) begin
                     bitCnt <= bitCnt + 4'd1;
                  end
               end
               WR_ACK: begin
                  if (sclFall) begin
                     if (bitCnt == 4'd8) begin
                        sdaOe  <= 1'b1;
                        bitCnt <= 4'd0;
                     end else begin
                        state <= WR;
                        sdaOe <= 1'b0;
                     end
                  end
               end
               RD: begin
                  if (sclFall) begin
                     if (bitCnt == 4'd7) begin
                        sdaOe  <= 1'b0;
                        state  <= RD_ACK;
                        bitCnt <= 4'd0;
                     end else begin
                        shiftReg <= {shiftReg[6:0], 1'b0};
                        sdaOe    <= ~shiftReg[6];
                        bitCnt   <= bitCnt + 4'd1;
                     end
                  end
               end
               RD_ACK: begin
                  if (sclRise && sdaNow) begin
                     state   <= IGNORE;
                     busyReg <= 1'b0;
                  end else if (sclFall) begin
                     state    <= RD;
                     shiftReg <= bus.tx_data;
                     txReq    <= 1'b1;
                     sdaOe    <= ~bus.tx_data[7];
                  end
               end
               default: begin
                  state <= IDLE;
                  sdaOe <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.sda_oe   = sdaOe;
   assign bus.tx_req   = txReq;
   assign bus.rx_data  = rxData;
   assign bus.rx_valid = rxValid;
   assign bus.busy     = busyReg;
   assign bus.bus_err  = busErr;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-banged I2C initiator on an open-drain SDA,
// directed scenarios plus randomized transfers checked against a
// transaction-level expectation built from the address, direction and bytes.
module tb_i2c_slave;

   localparam int         Q    = 8;
   localparam logic [6:0] ADDR = 7'h39;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       masterScl;
   logic       masterSda;
   logic [7:0] txData;

   int compared   = 0;
   int mismatched = 0;
   int rxCount    = 0;
   int txCount    = 0;
   int errCount   = 0;
   int oeCount    = 0;

   i2c_slave_if bus ();

   assign bus.scl     = masterScl;
   assign bus.sda_in  = masterSda & ~bus.sda_oe;
   assign bus.tx_data = txData;

   i2c_slave #(.SLAVE_ADDR(ADDR), .SYNC_STAGES(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running system clock, much faster than SCL.
   always #5 clk = ~clk;

   // Pulse and drive-cycle counters sampled away from the active edge.
   always @(negedge clk) begin
      if (bus.rx_valid) rxCount++;
      if (bus.tx_req)   txCount++;
      if (bus.bus_err)  errCount++;
      if (bus.sda_oe)   oeCount++;
   end

   task automatic applyStimulus(input logic sclVal, input logic sdaVal);
      masterScl = sclVal;
      masterSda = sdaVal;
      repeat (Q) @(negedge clk);
   endtask

   task automatic busStart();
      if (masterScl == 1'b0) begin
         applyStimulus(1'b0, 1'b1);
         applyStimulus(1'b1, 1'b1);
      end
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
   endtask

   task automatic busStop();
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1);
   endtask

   task automatic clockBit(input logic b, output logic seen);
      applyStimulus(1'b0, b);
      applyStimulus(1'b1, b);
      seen = bus.sda_in;
      applyStimulus(1'b1, b);
      applyStimulus(1'b0, b);
   endtask

   task automatic sendByte(input logic [7:0] b, output logic acked);
      logic s;
      for (int i = 7; i >= 0; i--) clockBit(b[i], s);
      clockBit(1'b1, s);
      acked = ~s;
   endtask

   task automatic readByte(output logic [7:0] v);
      logic s;
      v = 8'h00;
      for (int i = 0; i < 8; i++) begin
         clockBit(1'b1, s);
         v = {v[6:0], s};
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      compared++;
      if (bus.sda_oe !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_sda_oe: got %b want 0", bus.sda_oe); end
      compared++;
      if (bus.rx_data !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_rx_data: got %h want 00", bus.rx_data); end
      compared++;
      if ({bus.rx_valid, bus.tx_req, bus.busy, bus.bus_err} !== 4'b0000) begin
         mismatched++;
         $display("[TB] FAIL reset_flags: got %b want 0000", {bus.rx_valid, bus.tx_req, bus.busy, bus.bus_err});
      end
      rst_n = 1'b1;
      repeat (4 * Q) @(negedge clk);
   endtask

   task automatic test_write();
      logic acked;
      int rx0 = rxCount;
      int er0 = errCount;
      busStart();
      sendByte(8'h72, acked);
      compared++;
      if (acked !== 1'b1) begin mismatched++; $display("[TB] FAIL write_addr_ack: got %b want 1", acked); end
      sendByte(8'hCA, acked);
      compared++;
      if (acked !== 1'b1) begin mismatched++; $display("[TB] FAIL write_data_ack: got %b want 1", acked); end
      compared++;
      if (bus.busy !== 1'b1) begin mismatched++; $display("[TB] FAIL write_busy_mid: got %b want 1", bus.busy); end
      busStop();
      compared++;
      if (bus.rx_data !== 8'hCA) begin mismatched++; $display("[TB] FAIL write_rx_data: got %h want ca", bus.rx_data); end
      compared++;
      if (rxCount - rx0 !== 1) begin mismatched++; $display("[TB] FAIL write_rx_valid_count: got %0d want 1", rxCount - rx0); end
      compared++;
      if (bus.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL write_busy_after_stop: got %b want 0", bus.busy); end
      compared++;
      if (errCount - er0 !== 0) begin mismatched++; $display("[TB] FAIL write_no_bus_err: got %0d want 0", errCount - er0); end
   endtask

   task automatic test_read();
      logic       acked;
      logic       s;
      logic [7:0] got;
      int tx0 = txCount;
      int er0 = errCount;
      txData = 8'hA5;
      busStart();
      sendByte(8'h73, acked);
      compared++;
      if (acked !== 1'b1) begin mismatched++; $display("[TB] FAIL read_addr_ack: got %b want 1", acked); end
      readByte(got);
      compared++;
      if (got !== 8'hA5) begin mismatched++; $display("[TB] FAIL read_bits: got %h want a5", got); end
      clockBit(1'b1, s);
      compared++;
      if (bus.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL read_busy_after_nack: got %b want 0", bus.busy); end
      busStop();
      compared++;
      if (txCount - tx0 !== 1) begin mismatched++; $display("[TB] FAIL read_tx_req_count: got %0d want 1", txCount - tx0); end
      compared++;
      if (errCount - er0 !== 0) begin mismatched++; $display("[TB] FAIL read_no_bus_err: got %0d want 0", errCount - er0); end
   endtask

   task automatic test_mismatch();
      logic acked;
      int rx0 = rxCount;
      int oe0 = oeCount;
      busStart();
      sendByte(8'h50, acked);
      compared++;
      if (acked !== 1'b0) begin mismatched++; $display("[TB] FAIL mismatch_ack: got %b want 0", acked); end
      sendByte(8'h3C, acked);
      compared++;
      if (bus.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL mismatch_busy: got %b want 0", bus.busy); end
      busStop();
      compared++;
      if (oeCount - oe0 !== 0) begin mismatched++; $display("[TB] FAIL mismatch_sda_oe_cycles: got %0d want 0", oeCount - oe0); end
      compared++;
      if (rxCount - rx0 !== 0) begin mismatched++; $display("[TB] FAIL mismatch_rx_valid: got %0d want 0", rxCount - rx0); end
   endtask

   task automatic test_repeated_start();
      logic       acked;
      logic       s;
      logic [7:0] got;
      logic [7:0] first  = 8'h6E;
      logic [7:0] second = 8'h93;
      int tx0 = txCount;
      int er0 = errCount;
      busStart();
      sendByte(8'h72, acked);
      sendByte(8'h11, acked);
      compared++;
      if (acked !== 1'b1) begin mismatched++; $display("[TB] FAIL rs_write_ack: got %b want 1", acked); end
      txData = first;
      busStart();
      sendByte(8'h73, acked);
      compared++;
      if (acked !== 1'b1) begin mismatched++; $display("[TB] FAIL rs_read_addr_ack: got %b want 1", acked); end
      readByte(got);
      compared++;
      if (got !== first) begin mismatched++; $display("[TB] FAIL rs_read_byte0: got %h want %h", got, first); end
      txData = second;
      clockBit(1'b0, s);
      readByte(got);
      compared++;
      if (got !== second) begin mismatched++; $display("[TB] FAIL rs_read_byte1: got %h want %h", got, second); end
      clockBit(1'b1, s);
      busStop();
      compared++;
      if (bus.rx_data !== 8'h11) begin mismatched++; $display("[TB] FAIL rs_rx_data: got %h want 11", bus.rx_data); end
      compared++;
      if (txCount - tx0 !== 2) begin mismatched++; $display("[TB] FAIL rs_tx_req_count: got %0d want 2", txCount - tx0); end
      compared++;
      if (errCount - er0 !== 0) begin mismatched++; $display("[TB] FAIL rs_no_bus_err: got %0d want 0", errCount - er0); end
   endtask

   task automatic test_partial_stop();
      logic acked;
      logic s;
      int rx0 = rxCount;
      int er0 = errCount;
      busStart();
      sendByte(8'h72, acked);
      clockBit(1'b1, s);
      clockBit(1'b0, s);
      clockBit(1'b1, s);
      clockBit(1'b1, s);
      busStop();
      compared++;
      if (errCount - er0 !== 1) begin mismatched++; $display("[TB] FAIL partial_bus_err: got %0d want 1", errCount - er0); end
      compared++;
      if (rxCount - rx0 !== 0) begin mismatched++; $display("[TB] FAIL partial_rx_valid: got %0d want 0", rxCount - rx0); end
      compared++;
      if ({bus.busy, bus.sda_oe} !== 2'b00) begin mismatched++; $display("[TB] FAIL partial_idle: got %b want 00", {bus.busy, bus.sda_oe}); end
   endtask

   task automatic test_reset_during_read();
      logic       acked;
      logic [7:0] data;
      int rx0;
      txData = 8'h3C;
      busStart();
      sendByte(8'h73, acked);
      repeat (Q) @(negedge clk);
      compared++;
      if (bus.sda_oe !== 1'b1) begin mismatched++; $display("[TB] FAIL rstrd_driving: got %b want 1", bus.sda_oe); end
      rst_n = 1'b0;
      #1;
      compared++;
      if (bus.sda_oe !== 1'b0) begin mismatched++; $display("[TB] FAIL rstrd_sda_oe_release: got %b want 0", bus.sda_oe); end
      masterScl = 1'b1;
      masterSda = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (4 * Q) @(negedge clk);
      rx0  = rxCount;
      data = 8'($urandom_range(0, 255));
      busStart();
      sendByte(8'h72, acked);
      compared++;
      if (acked !== 1'b1) begin mismatched++; $display("[TB] FAIL rstrd_addr_ack: got %b want 1", acked); end
      sendByte(data, acked);
      busStop();
      compared++;
      if (bus.rx_data !== data || rxCount - rx0 !== 1) begin
         mismatched++;
         $display("[TB] FAIL rstrd_write: got %h/%0d want %h/1", bus.rx_data, rxCount - rx0, data);
      end
   endtask

   task automatic test_random();
      logic [6:0] addr7;
      logic       rw;
      logic       acked;
      logic       s;
      logic       expectMatch;
      logic [7:0] got;
      logic [7:0] bytes[$];
      int n, rx0, tx0, oe0;
      int er0 = errCount;
      for (int t = 0; t < 6; t++) begin
         addr7 = 7'($urandom_range(0, 127));
         if ($urandom_range(0, 1) == 1) addr7 = ADDR;
         rw = 1'($urandom_range(0, 1));
         n  = int'($urandom_range(1, 3));
         bytes.delete();
         for (int k = 0; k < n; k++) bytes.push_back(8'($urandom_range(0, 255)));
         expectMatch = (addr7 == ADDR);
         rx0 = rxCount;
         tx0 = txCount;
         oe0 = oeCount;
         txData = bytes[0];
         busStart();
         sendByte({addr7, rw}, acked);
         compared++;
         if (acked !== expectMatch) begin mismatched++; $display("[TB] FAIL rand_addr_ack t=%0d: got %b want %b", t, acked, expectMatch); end
         if (!expectMatch) begin
            sendByte(bytes[0], acked);
            busStop();
            compared++;
            if (oeCount - oe0 !== 0 || rxCount - rx0 !== 0) begin
               mismatched++;
               $display("[TB] FAIL rand_ignored t=%0d: got oe=%0d rx=%0d want 0/0", t, oeCount - oe0, rxCount - rx0);
            end
         end else if (!rw) begin
            for (int k = 0; k < n; k++) begin
               sendByte(bytes[k], acked);
               compared++;
               if (acked !== 1'b1) begin mismatched++; $display("[TB] FAIL rand_wr_ack t=%0d k=%0d: got %b want 1", t, k, acked); end
            end
            busStop();
            compared++;
            if (bus.rx_data !== bytes[n-1] || rxCount - rx0 !== n) begin
               mismatched++;
               $display("[TB] FAIL rand_wr_rx t=%0d: got %h/%0d want %h/%0d", t, bus.rx_data, rxCount - rx0, bytes[n-1], n);
            end
         end else begin
            for (int k = 0; k < n; k++) begin
               readByte(got);
               compared++;
               if (got !== bytes[k]) begin mismatched++; $display("[TB] FAIL rand_rd_byte t=%0d k=%0d: got %h want %h", t, k, got, bytes[k]); end
               if (k < n - 1) begin
                  txData = bytes[k+1];
                  clockBit(1'b0, s);
               end else begin
                  clockBit(1'b1, s);
               end
            end
            busStop();
            compared++;
            if (txCount - tx0 !== n) begin mismatched++; $display("[TB] FAIL rand_rd_tx_req t=%0d: got %0d want %0d", t, txCount - tx0, n); end
         end
         compared++;
         if (bus.busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rand_busy_end t=%0d: got %b want 0", t, bus.busy); end
      end
      compared++;
      if (errCount - er0 !== 0) begin mismatched++; $display("[TB] FAIL rand_no_bus_err: got %0d want 0", errCount - er0); end
   endtask

   // Scenario sequence; every wait is a fixed cycle count so the run always ends.
   initial begin
      rst_n     = 1'b1;
      masterScl = 1'b1;
      masterSda = 1'b1;
      txData    = 8'h00;
      #2;
      test_reset();
      test_write();
      test_read();
      test_mismatch();
      test_repeated_start();
      test_partial_stop();
      test_reset_during_read();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'b0111001, the 7-bit bus address this responder answers to.
REQ-002 Parameter SYNC_STAGES, default 2, the synchronizer depth for scl and sda_in (minimum 2).
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 scl  input  1  bus clock from the initiator; asynchronous to clk.
REQ-006 sda_in  input  1  sampled bus data line.
REQ-007 sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-008 tx_data  input  8  byte returned on a read transfer; captured at tx_req.
REQ-009 tx_req  output  1  one-clk pulse; tx_data is captured in the same cycle.
REQ-010 rx_data  output  8  last byte received on a write transfer.
REQ-011 rx_valid  output  1  one-clk pulse when rx_data updates.
REQ-012 busy  output  1  high from an addressed START until STOP or NACK-terminated read.
REQ-013 bus_err  output  1  one-clk pulse on START or STOP inside a byte (bit counter not 0).

Function
REQ-014 scl and sda_in SHALL pass through SYNC_STAGES flops; all edge/condition detection SHALL use the synchronized values and their 1-cycle delayed copies.
REQ-015 START = synced SDA falling while synced SCL high; STOP = synced SDA rising while synced SCL high; a START while not IDLE (repeated START) SHALL re-enter ADDR.
REQ-016 Data SHALL be sampled on synced SCL rising edge, MSB first; sda_oe SHALL change only in the clk cycle after a synced SCL falling edge is detected.
REQ-017 States: IDLE, ADDR, ADDR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE.
REQ-018 IDLE -> ADDR on START; bit counter cleared to 0.
REQ-019 ADDR: shift 8 bits (7 address + R/W, R/W = bit 0, 1 = read); after 8th rising edge: match -> ADDR_ACK, mismatch -> IGNORE.
REQ-020 ADDR_ACK: drive sda_oe=1 for the 9th SCL period; on its falling edge go to WR (R/W=0) or RD (R/W=1); entering RD SHALL pulse tx_req and load the shift register from tx_data.
REQ-021 WR: shift 8 bits; on 8th rising edge rx_data <= byte and rx_valid pulses; then WR_ACK drives sda_oe=1 for the 9th period, returns to WR.
REQ-022 RD: sda_oe = ~shift_reg[7] per bit, shifted on each SCL falling edge; after 8 bits release (sda_oe=0) -> RD_ACK.
REQ-023 RD_ACK: sample SDA on 9th rising edge; low (ACK) -> pulse tx_req, reload, RD; high (NACK) -> IGNORE with busy=0.
REQ-024 IGNORE: sda_oe=0; wait for START or STOP only.
REQ-025 STOP in any state SHALL go to IDLE, sda_oe=0, busy=0, no rx_valid for a partial byte.
REQ-026 Bit counter 4 bits, wraps 8->0 at each ACK slot; START/STOP with counter not 0 outside IDLE/IGNORE SHALL pulse bus_err.
REQ-027 Simultaneous STOP detection and rising-edge sampling in one cycle: STOP takes priority.
REQ-028 sda_oe SHALL never assert in IDLE or IGNORE; the responder SHALL not stretch SCL.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, sda_oe=0, rx_data=8'h00, rx_valid=0, tx_req=0, busy=0, bus_err=0, counters and shift register 0, synchronizer flops to 1 (bus idle).
REQ-030 Release of rst_n mid-transfer SHALL leave the block in IDLE until the next START; no spurious START detected from synchronizer reset values.

Verification
REQ-031 Write: START, 0x72 (addr 0x39, W), 0xCA, STOP -> sda_oe=1 in both ACK slots, rx_valid once, rx_data=8'hCA, busy low after STOP.
REQ-032 Read: tx_data=8'hA5, START, 0x73, master NACK -> SDA bits 1,0,1,0,0,1,0,1, tx_req once, IGNORE then IDLE at STOP.
REQ-033 Address mismatch: START, 0x50 -> sda_oe stays 0 throughout, busy 0, no rx_valid.
REQ-034 Repeated START: write 0x72,0x11 then START, 0x73, ACK, NACK -> rx_data=8'h11, two tx_req pulses, second byte per tx_data.
REQ-035 STOP after 4 data bits of a write -> bus_err pulse, no rx_valid, IDLE, sda_oe=0.
REQ-036 rst_n low during RD with sda_oe=1 -> sda_oe=0 same cycle; next valid START/0x72 transfer completes normally.
